prescaled_counter: RTL and testbench
====================================

PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
REQ-001 Parameter WIDTH, default 9, count register width (>=2).
REQ-002 Parameter PRESCALE, default 3250000, CLOCK_IN cycles per count tick (>=1).
REQ-003 CLOCK_IN  in  1  sole clock, rising edge.
REQ-004 RESET  in  1  asynchronous, active-high reset.
REQ-005 ENABLE  in  1  count on tick when high.
REQ-006 CLEAR  in  1  synchronous clear, acts every cycle.
REQ-007 LOAD  in  1  synchronous load of LOAD_VALUE, acts every cycle.
REQ-008 LOAD_VALUE  in  WIDTH  value for LOAD.
REQ-009 UP  in  1  direction: 1 up, 0 down.
REQ-010 SATURATE  in  1  0 wrap at terminal, 1 hold at terminal.
REQ-011 LIMIT  in  WIDTH  upper count bound, inclusive.
REQ-012 CAPTURE  in  1  snapshot strobe.
REQ-013 DATA  out  WIDTH  current count, registered.
REQ-014 TICK  out  1  registered one-cycle pulse per prescaler period.
REQ-015 TRIGGER  out  1  combinational: DATA>=LIMIT when UP=1, DATA==0 when UP=0.
REQ-016 TC_PULSE  out  1  registered one-cycle pulse on terminal event.
REQ-017 CAPTURE_DATA  out  WIDTH  last snapshot of DATA.

Function
REQ-018 Prescaler SHALL run free 0..PRESCALE-1 regardless of ENABLE; tick condition = prescaler==PRESCALE-1, then prescaler returns to 0.
REQ-019 TICK SHALL be high the cycle after each tick condition; PRESCALE=1 gives TICK high every cycle after reset release.
REQ-020 Per-cycle priority SHALL be CLEAR > LOAD > tick-count.
REQ-021 CLEAR SHALL set DATA=0 and prescaler=0 next edge, suppressing that cycle's tick and TC_PULSE.
REQ-022 LOAD SHALL set DATA=min(LOAD_VALUE,LIMIT) next edge; prescaler unaffected; tick suppressed for DATA.
REQ-023 On tick with ENABLE=1, UP=1: DATA<LIMIT -> DATA+1; DATA>=LIMIT -> 0 (SATURATE=0) or LIMIT (SATURATE=1), TC_PULSE=1 next cycle.
REQ-024 On tick with ENABLE=1, UP=0: DATA>0 -> DATA-1; DATA==0 -> LIMIT (SATURATE=0) or 0 (SATURATE=1), TC_PULSE=1 next cycle.
REQ-025 Saturated hold SHALL reassert TC_PULSE on every subsequent enabled tick.
REQ-026 LIMIT lowered below DATA SHALL take effect on next tick per REQ-023 (no out-of-range count).
REQ-027 Arithmetic SHALL be WIDTH-bit unsigned, no carry out; LIMIT=0 keeps DATA at 0.

Reset
REQ-028 RESET high SHALL asynchronously clear prescaler, DATA, TICK, TC_PULSE, CAPTURE_DATA to 0; TRIGGER then follows REQ-015.
REQ-029 Reset mid-period SHALL discard partial prescale; first tick condition occurs PRESCALE cycles after release.

Configuration
REQ-030 Macro PRESCALED_COUNTER_CAPTURE_EN defined: CAPTURE high SHALL load CAPTURE_DATA with DATA (pre-update value) next edge.
REQ-031 Macro undefined: capture register SHALL not be built; CAPTURE ignored; CAPTURE_DATA tied 0; ports remain.

Structure
REQ-032 Package prescaled_counter_pkg SHALL hold direction/mode constants (DIR_UP, DIR_DOWN, MODE_WRAP, MODE_SAT) and default WIDTH/PRESCALE.
REQ-033 Prescaler SHALL be sub-module tick_divider (params PRESCALE; ports CLOCK_IN, RESET, CLEAR, TICK_EN); prescaler width = $clog2(PRESCALE), min 1.

Verification (PRESCALE=4, WIDTH=4 unless noted)
REQ-034 UP=1, SATURATE=0, LIMIT=5, ENABLE=1, 30 cycles -> DATA 0,1,..,5,0 every 4 cycles; TC_PULSE once at 5->0; TRIGGER high while DATA=5.
REQ-035 UP=0, SATURATE=1, LOAD_VALUE=2 -> DATA 2,1,0,0; TC_PULSE on each tick at 0.
REQ-036 CLEAR and LOAD same cycle as tick condition -> DATA=0, prescaler=0, no TC_PULSE; next TICK 4 cycles later.
REQ-037 LOAD_VALUE=12, LIMIT=9 -> DATA=9; then LIMIT=3 -> next up tick DATA=0 with TC_PULSE.
REQ-038 RESET pulse mid-period, async (no clock edge) -> all outputs 0 immediately; first TICK 4 cycles after release; PRESCALE=1 -> TICK every cycle.
REQ-039 With PRESCALED_COUNTER_CAPTURE_EN, CAPTURE at DATA=7 -> CAPTURE_DATA=7 held; without macro -> CAPTURE_DATA stays 0.

Source files
------------

// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled up/down counter.
// Direction and terminal-mode encodings plus default sizing.
package prescaled_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 9;
    localparam int unsigned DEFAULT_PRESCALE = 3250000;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/prescaled_counter_tick_divider.sv
// Free-running prescaler: counts 0..PRESCALE-1 and flags the last cycle.
// CLEAR restarts the period; TICK_EN is the combinational tick condition.
module tick_divider
    import prescaled_counter_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic CLOCK_IN,
    input  logic RESET,
    input  logic CLEAR,
    output logic TICK_EN
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign TICK_EN = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (CLEAR || TICK_EN) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Prescaled up/down counter with limit, wrap/saturate and terminal pulse.
// Define PRESCALED_COUNTER_CAPTURE_EN to build the CAPTURE snapshot register.
module prescaled_counter
    import prescaled_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             CLOCK_IN,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             CLEAR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    input  logic             UP,
    input  logic             SATURATE,
    input  logic [WIDTH-1:0] LIMIT,
    input  logic             CAPTURE,
    output logic [WIDTH-1:0] DATA,
    output logic             TICK,
    output logic             TRIGGER,
    output logic             TC_PULSE,
    output logic [WIDTH-1:0] CAPTURE_DATA
);

    logic             tick_en_c;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             tick_q;
    logic             tick_d;
    logic             tc_q;
    logic             tc_d;

    tick_divider #(
        .PRESCALE (PRESCALE)
    ) u_tick_divider (
        .CLOCK_IN (CLOCK_IN),
        .RESET    (RESET),
        .CLEAR    (CLEAR),
        .TICK_EN  (tick_en_c)
    );

    // CLEAR beats LOAD beats the enabled tick; a count above LIMIT terminates on the next up tick.
    always_comb begin
        data_d = data_q;
        tc_d   = 1'b0;
        tick_d = tick_en_c && !CLEAR;
        if (CLEAR) begin
            data_d = '0;
        end else if (LOAD) begin
            data_d = (LOAD_VALUE > LIMIT) ? LIMIT : LOAD_VALUE;
        end else if (tick_en_c && ENABLE) begin
            if (UP == DIR_UP) begin
                if (data_q < LIMIT) begin
                    data_d = data_q + WIDTH'(1);
                end else begin
                    data_d = (SATURATE == MODE_SAT) ? LIMIT : '0;
                    tc_d   = 1'b1;
                end
            end else begin
                if (data_q != '0) begin
                    data_d = data_q - WIDTH'(1);
                end else begin
                    data_d = (SATURATE == MODE_SAT) ? '0 : LIMIT;
                    tc_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            data_q <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            data_q <= data_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end

    assign DATA     = data_q;
    assign TICK     = tick_q;
    assign TC_PULSE = tc_q;
    assign TRIGGER  = (UP == DIR_UP) ? (data_q >= LIMIT) : (data_q == '0);

`ifdef PRESCALED_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] cap_d;

    // Snapshot takes the count as it stands before this edge's update.
    always_comb begin
        cap_d = cap_q;
        if (CAPTURE) begin
            cap_d = data_q;
        end
    end

    always_ff @(posedge CLOCK_IN or posedge RESET) begin
        if (RESET) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

    assign CAPTURE_DATA = cap_q;
`else
    logic capture_unused;
    assign capture_unused = CAPTURE;
    assign CAPTURE_DATA   = '0;
`endif

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter (WIDTH=4, PRESCALE=4, plus a PRESCALE=1 instance).
module tb_prescaled_counter;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       ENABLE = 1'b0;
    logic       CLEAR = 1'b0;
    logic       LOAD = 1'b0;
    logic [3:0] LOAD_VALUE = '0;
    logic       UP = 1'b1;
    logic       SATURATE = 1'b0;
    logic [3:0] LIMIT = 4'd5;
    logic       CAPTURE = 1'b0;

    logic [3:0] DATA;
    logic       TICK;
    logic       TRIGGER;
    logic       TC_PULSE;
    logic [3:0] CAPTURE_DATA;

    logic [3:0] d1_data;
    logic       d1_tick;
    logic       d1_trigger;
    logic       d1_tc;
    logic [3:0] d1_cap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prescaled_counter #(.WIDTH(4), .PRESCALE(4)) dut (
        .CLOCK_IN(clk), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR), .LOAD(LOAD),
        .LOAD_VALUE(LOAD_VALUE), .UP(UP), .SATURATE(SATURATE), .LIMIT(LIMIT),
        .CAPTURE(CAPTURE), .DATA(DATA), .TICK(TICK), .TRIGGER(TRIGGER),
        .TC_PULSE(TC_PULSE), .CAPTURE_DATA(CAPTURE_DATA)
    );

    prescaled_counter #(.WIDTH(4), .PRESCALE(1)) dut1 (
        .CLOCK_IN(clk), .RESET(RESET), .ENABLE(ENABLE), .CLEAR(CLEAR), .LOAD(LOAD),
        .LOAD_VALUE(LOAD_VALUE), .UP(UP), .SATURATE(SATURATE), .LIMIT(LIMIT),
        .CAPTURE(CAPTURE), .DATA(d1_data), .TICK(d1_tick), .TRIGGER(d1_trigger),
        .TC_PULSE(d1_tc), .CAPTURE_DATA(d1_cap)
    );

    typedef struct {
        bit         rst;
        bit         load;
        logic [3:0] lv;
        bit         up;
        bit         sat;
        logic [3:0] limit;
        logic [3:0] exp_data;
        bit         exp_tick;
        bit         exp_tc;
        bit         exp_trig;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit load, logic [3:0] lv, bit up, bit sat,
                                logic [3:0] lim, logic [3:0] d, bit tk, bit tc, bit tr);
        vec_t v;
        v.rst = rst; v.load = load; v.lv = lv; v.up = up; v.sat = sat; v.limit = lim;
        v.exp_data = d; v.exp_tick = tk; v.exp_tc = tc; v.exp_trig = tr;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset held across two edges, released just after an edge so the next edge is E1.
    task automatic do_reset();
        RESET = 1'b1;
        ENABLE = 1'b0; CLEAR = 1'b0; LOAD = 1'b0; LOAD_VALUE = '0;
        UP = 1'b1; SATURATE = 1'b0; LIMIT = 4'd5; CAPTURE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [3:0] exp_cap7;
        logic [3:0] exp_cap8;
        int d;

        // up, wrap, LIMIT=5 for 30 cycles
        for (int k = 1; k <= 30; k++) begin
            d = (k / 4) % 6;
            tbl.push_back(mk(k == 1, 0, 0, 1, 0, 5, 4'(d), (k % 4) == 0, k == 24, d == 5));
        end
        // load 2, down, saturate
        for (int k = 1; k <= 16; k++) begin
            d = (k < 4) ? 2 : (k < 8) ? 1 : 0;
            tbl.push_back(mk(k == 1, k == 1, 2, 0, 1, 5, 4'(d), (k % 4) == 0,
                             (k == 12) || (k == 16), d == 0));
        end
        // LIMIT=0 pins the count at 0 and every tick is terminal
        for (int k = 1; k <= 8; k++) begin
            tbl.push_back(mk(k == 1, 0, 0, 1, 0, 0, 0, (k % 4) == 0, (k % 4) == 0, 1));
        end
        // down, wrap, LIMIT=3: 0 -> 3 -> 2
        for (int k = 1; k <= 8; k++) begin
            d = (k < 4) ? 0 : (k < 8) ? 3 : 2;
            tbl.push_back(mk(k == 1, 0, 0, 0, 0, 3, 4'(d), (k % 4) == 0, k == 4, d == 0));
        end
        // up, saturate, LIMIT=1: hold at 1, pulse on every later tick
        for (int k = 1; k <= 12; k++) begin
            d = (k < 4) ? 0 : 1;
            tbl.push_back(mk(k == 1, 0, 0, 1, 1, 1, 4'(d), (k % 4) == 0,
                             (k == 8) || (k == 12), d == 1));
        end

        do_reset();
        RESET = 1'b1;
        #1;
        check("rst_data", 0, DATA, 0);
        check("rst_tick", 0, TICK, 0);
        check("rst_tc", 0, TC_PULSE, 0);
        check("rst_cap", 0, CAPTURE_DATA, 0);
        check("rst_trig", 0, TRIGGER, 0);
        check("rst_d1_tick", 0, d1_tick, 0);

        foreach (tbl[i]) begin
            v = tbl[i];
            if (v.rst) do_reset();
            ENABLE = 1'b1; CLEAR = 1'b0; CAPTURE = 1'b0;
            LOAD = v.load; LOAD_VALUE = v.lv; UP = v.up; SATURATE = v.sat; LIMIT = v.limit;
            step();
            check("tbl_data", i, DATA, v.exp_data);
            check("tbl_tick", i, TICK, v.exp_tick);
            check("tbl_tc", i, TC_PULSE, v.exp_tc);
            check("tbl_trig", i, TRIGGER, v.exp_trig);
        end

        // CLEAR and LOAD together on the tick-condition cycle
        do_reset();
        ENABLE = 1'b1; LOAD = 1'b1; LOAD_VALUE = 4'd5;
        step();
        check("cl_load", 1, DATA, 5);
        LOAD = 1'b0;
        step();
        step();
        CLEAR = 1'b1; LOAD = 1'b1; LOAD_VALUE = 4'd4;
        step();
        check("cl_data", 4, DATA, 0);
        check("cl_tick", 4, TICK, 0);
        check("cl_tc", 4, TC_PULSE, 0);
        CLEAR = 1'b0; LOAD = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            step();
            check("cl_notick", k, TICK, 0);
        end
        step();
        check("cl_tick8", 8, TICK, 1);
        check("cl_data8", 8, DATA, 1);
        check("cl_tc8", 8, TC_PULSE, 0);

        // load clamps to LIMIT, then LIMIT is lowered below DATA
        do_reset();
        ENABLE = 1'b1; LIMIT = 4'd9; LOAD = 1'b1; LOAD_VALUE = 4'd12;
        step();
        check("lim_clamp", 1, DATA, 9);
        LOAD = 1'b0; LIMIT = 4'd3;
        #1;
        check("lim_trig", 1, TRIGGER, 1);
        step();
        step();
        check("lim_hold", 3, DATA, 9);
        step();
        check("lim_data", 4, DATA, 0);
        check("lim_tc", 4, TC_PULSE, 1);
        step();
        check("lim_tc_off", 5, TC_PULSE, 0);

        // asynchronous reset mid-period
        do_reset();
        ENABLE = 1'b1;
        repeat (4) step();
        check("ar_pre_data", 4, DATA, 1);
        check("ar_pre_tick", 4, TICK, 1);
        check("ar_d1_tick", 4, d1_tick, 1);
        #2;
        RESET = 1'b1;
        #1;
        check("ar_data", 0, DATA, 0);
        check("ar_tick", 0, TICK, 0);
        check("ar_tc", 0, TC_PULSE, 0);
        check("ar_d1_tick0", 0, d1_tick, 0);
        check("ar_d1_data", 0, d1_data, 0);
        @(posedge clk);
        #1;
        RESET = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("ar_tick_rel", k, TICK, k == 4);
            check("ar_d1_tick_rel", k, d1_tick, 1);
        end

        // snapshot register
`ifdef PRESCALED_COUNTER_CAPTURE_EN
        exp_cap7 = 4'd7;
        exp_cap8 = 4'd8;
`else
        exp_cap7 = 4'd0;
        exp_cap8 = 4'd0;
`endif
        do_reset();
        ENABLE = 1'b1; LIMIT = 4'd9; LOAD = 1'b1; LOAD_VALUE = 4'd7;
        step();
        LOAD = 1'b0; CAPTURE = 1'b1;
        step();
        check("cap_first", 2, CAPTURE_DATA, exp_cap7);
        CAPTURE = 1'b0;
        step();
        check("cap_held", 3, CAPTURE_DATA, exp_cap7);
        CAPTURE = 1'b1;
        step();
        check("cap_data4", 4, DATA, 8);
        check("cap_pre_update", 4, CAPTURE_DATA, exp_cap7);
        step();
        check("cap_second", 5, CAPTURE_DATA, exp_cap8);
        CAPTURE = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
